// File: rtl/otg_hpi_pkg.sv
// ---------------------------------------------------------------------------
// otg_hpi_pkg
// Shared definitions for the CY7C67200 (EZ-OTG) Host Port Interface
// sequencer: the FSM state type, the HPI register select codes and the width
// of the phase timing counter.
// ---------------------------------------------------------------------------
package otg_hpi_pkg;

    // Width of the phase down-counter; every timing parameter fits in it.
    localparam int CNT_W = 4;

    // HPI register select codes, as presented on otg_addr.
    localparam logic [1:0] HPI_DATA    = 2'd0;
    localparam logic [1:0] HPI_MAILBOX = 2'd1;
    localparam logic [1:0] HPI_ADDRESS = 2'd2;
    localparam logic [1:0] HPI_STATUS  = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        DONE,
        RECOVER
    } hpi_state_t;

endpackage

// File: rtl/hpi_phase_counter.sv
// ---------------------------------------------------------------------------
// hpi_phase_counter
// Loadable down-counter that times each HPI access phase. A phase of N
// cycles is started by loading N-1; the phase ends in the cycle where zero
// is high. The count saturates at zero.
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous, active-high reset (count clears to 0)
//   load   in   load value into the count this cycle
//   value  in   CNT_W-bit load value
//   zero   out  high while the count is 0
// ---------------------------------------------------------------------------
module hpi_phase_counter
    import otg_hpi_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/otg_hpi_ctrl.sv
// ---------------------------------------------------------------------------
// otg_hpi_ctrl
// Hardware sequencer for the CY7C67200 Host Port Interface. Accepts one
// Avalon-MM access at a time and turns it into an HPI read or write cycle
// with programmable setup / strobe / hold / recovery timing.
// Ports:
//   clk, reset        system clock, asynchronous active-high reset
//   address[1:0]      HPI register select (DATA, MAILBOX, ADDRESS, STATUS)
//   chipselect, read, write, writedata[15:0]   Avalon slave request side
//   readdata[15:0]    registered read data
//   waitrequest       combinational Avalon stall; low only in DONE
//   otg_addr[1:0]     registered HPI address
//   otg_cs_n, otg_rd_n, otg_wr_n   active-low HPI strobes
//   otg_data_out[15:0], otg_data_oe   HPI data and its tristate enable
//   otg_data_in[15:0] HPI bus readback
//   busy              high whenever the sequencer is not IDLE
// ---------------------------------------------------------------------------
module otg_hpi_ctrl
    import otg_hpi_pkg::*;
#(
    parameter int unsigned SETUP_CYC    = 2,
    parameter int unsigned STROBE_CYC   = 4,
    parameter int unsigned HOLD_CYC     = 1,
    parameter int unsigned RECOVERY_CYC = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        read,
    input  logic        write,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        waitrequest,
    output logic [1:0]  otg_addr,
    output logic        otg_cs_n,
    output logic        otg_rd_n,
    output logic        otg_wr_n,
    output logic [15:0] otg_data_out,
    output logic        otg_data_oe,
    input  logic [15:0] otg_data_in,
    output logic        busy
);

    // Phase load values. RECOVER_LD is unused when RECOVERY_CYC is 0.
    localparam logic [CNT_W-1:0] SETUP_LD   = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LD  = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD    = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] RECOVER_LD = CNT_W'(RECOVERY_CYC - 1);

    hpi_state_t       state;
    hpi_state_t       next_state;
    logic             req;
    logic             dir_wr;
    logic             latch_req;
    logic             capture;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_value;
    logic             cnt_zero;
    logic             active;

    // Read has priority when the master raises both read and write.
    assign req = chipselect & (read | write);

    hpi_phase_counter u_phase_counter (
        .clk   (clk),
        .reset (reset),
        .load  (cnt_load),
        .value (cnt_value),
        .zero  (cnt_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        cnt_load   = 1'b0;
        cnt_value  = '0;
        latch_req  = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    latch_req  = 1'b1;
                    cnt_load   = 1'b1;
                    cnt_value  = SETUP_LD;
                    next_state = SETUP;
                end
            end
            SETUP: begin
                if (cnt_zero) begin
                    cnt_load   = 1'b1;
                    cnt_value  = STROBE_LD;
                    next_state = STROBE;
                end
            end
            STROBE: begin
                if (cnt_zero) begin
                    // Sample the bus on the last strobe cycle, while rd_n is still low.
                    capture    = ~dir_wr;
                    cnt_load   = 1'b1;
                    cnt_value  = HOLD_LD;
                    next_state = HOLD;
                end
            end
            HOLD: begin
                if (cnt_zero) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (RECOVERY_CYC == 0) begin
                    next_state = IDLE;
                end else begin
                    cnt_load   = 1'b1;
                    cnt_value  = RECOVER_LD;
                    next_state = RECOVER;
                end
            end
            RECOVER: begin
                if (cnt_zero) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Request attributes are captured only when leaving IDLE, so the master
    // changing them mid-access has no effect on the HPI cycle in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dir_wr       <= 1'b0;
            otg_addr     <= '0;
            otg_data_out <= '0;
        end else if (latch_req) begin
            dir_wr       <= write & ~read;
            otg_addr     <= address;
            otg_data_out <= writedata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
        end else if (capture) begin
            readdata <= otg_data_in;
        end
    end

    // Strobes decode from the registered state only; reset forces IDLE
    // asynchronously, which releases every strobe at once.
    always_comb begin
        active      = (state == SETUP) || (state == STROBE) || (state == HOLD);
        otg_cs_n    = ~active;
        otg_rd_n    = ~((state == STROBE) && !dir_wr);
        otg_wr_n    = ~((state == STROBE) && dir_wr);
        otg_data_oe = active && dir_wr;
        busy        = (state != IDLE);
        waitrequest = req && (state != DONE);
    end

endmodule

// File: tb/tb_otg_hpi_ctrl.sv
// ---------------------------------------------------------------------------
// tb_otg_hpi_ctrl
// Self-checking bench for otg_hpi_ctrl. Two instances run side by side: one
// with default timing and one with the fastest timing (1/1/1/0). A select
// signal routes the Avalon request to one of them; expectations come from
// the access timing windows computed with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_otg_hpi_ctrl;

    localparam int A_S = 2, A_ST = 4, A_H = 1, A_R = 2;
    localparam int B_S = 1, B_ST = 1, B_H = 1, B_R = 0;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic [1:0]  address;
    logic        chipselect, read, write;
    logic [15:0] writedata;
    logic [15:0] chip_val;
    logic        req_now;

    logic        a_cs, b_cs;
    logic [15:0] a_readdata, b_readdata, a_data_out, b_data_out, a_data_in, b_data_in;
    logic [1:0]  a_addr, b_addr;
    logic        a_wait, b_wait, a_cs_n, b_cs_n, a_rd_n, b_rd_n, a_wr_n, b_wr_n;
    logic        a_oe, b_oe, a_busy, b_busy;

    logic [15:0] obs_readdata, obs_data_out;
    logic [1:0]  obs_addr;
    logic        obs_wait, obs_cs_n, obs_rd_n, obs_wr_n, obs_oe, obs_busy;

    int total_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;

    logic [15:0] m_rd [2];
    logic [15:0] m_dout [2];
    logic [1:0]  m_addr [2];

    int cyc_cnt   = 0;
    int fall_last = 0;
    int fall_prev = 0;
    logic prev_cs_n = 1'b1;

    always #5 clk = ~clk;

    assign a_cs = chipselect & ~sel;
    assign b_cs = chipselect & sel;
    // HPI chip model: valid data only while its read strobe is low.
    assign a_data_in = !a_rd_n ? chip_val : 16'h5A5A;
    assign b_data_in = !b_rd_n ? chip_val : 16'h5A5A;

    assign obs_readdata = sel ? b_readdata : a_readdata;
    assign obs_data_out = sel ? b_data_out : a_data_out;
    assign obs_addr     = sel ? b_addr     : a_addr;
    assign obs_wait     = sel ? b_wait     : a_wait;
    assign obs_cs_n     = sel ? b_cs_n     : a_cs_n;
    assign obs_rd_n     = sel ? b_rd_n     : a_rd_n;
    assign obs_wr_n     = sel ? b_wr_n     : a_wr_n;
    assign obs_oe       = sel ? b_oe       : a_oe;
    assign obs_busy     = sel ? b_busy     : a_busy;

    otg_hpi_ctrl #(.SETUP_CYC(A_S), .STROBE_CYC(A_ST), .HOLD_CYC(A_H), .RECOVERY_CYC(A_R)) dut_a (
        .clk(clk), .reset(reset), .address(address), .chipselect(a_cs), .read(read),
        .write(write), .writedata(writedata), .readdata(a_readdata), .waitrequest(a_wait),
        .otg_addr(a_addr), .otg_cs_n(a_cs_n), .otg_rd_n(a_rd_n), .otg_wr_n(a_wr_n),
        .otg_data_out(a_data_out), .otg_data_oe(a_oe), .otg_data_in(a_data_in), .busy(a_busy)
    );

    otg_hpi_ctrl #(.SETUP_CYC(B_S), .STROBE_CYC(B_ST), .HOLD_CYC(B_H), .RECOVERY_CYC(B_R)) dut_b (
        .clk(clk), .reset(reset), .address(address), .chipselect(b_cs), .read(read),
        .write(write), .writedata(writedata), .readdata(b_readdata), .waitrequest(b_wait),
        .otg_addr(b_addr), .otg_cs_n(b_cs_n), .otg_rd_n(b_rd_n), .otg_wr_n(b_wr_n),
        .otg_data_out(b_data_out), .otg_data_oe(b_oe), .otg_data_in(b_data_in), .busy(b_busy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Free-running cycle index and cs_n falling-edge tracker, plus bus rules
    // that must hold in every cycle.
    always @(posedge clk) cyc_cnt++;

    always @(negedge clk) begin
        checkOutput("rd_wr_never_both_low", {31'd0, obs_rd_n | obs_wr_n}, 1);
        checkOutput("strobe_only_with_cs", {31'd0, (obs_rd_n & obs_wr_n) | ~obs_cs_n}, 1);
        checkOutput("no_oe_during_read", {31'd0, obs_oe & ~obs_rd_n}, 0);
        if (prev_cs_n && !obs_cs_n) begin
            fall_prev = fall_last;
            fall_last = cyc_cnt;
        end
        prev_cs_n = obs_cs_n;
    end

    // One access on the selected instance. Entered just after a rising edge.
    // pre: cycles the DUT is still recovering while req is already held.
    // drop_at: cycle index where the master illegally drops req (-1 = never).
    task automatic applyStimulus(input bit is_w, input bit both, input logic [1:0] addr,
                                 input logic [15:0] wdata, input logic [15:0] chip,
                                 input int pre, input int drop_at);
        int s, st, h, d, k;
        bit strobe_on, cs_on;
        logic [15:0] exp_rd;
        s  = sel ? B_S  : A_S;
        st = sel ? B_ST : A_ST;
        h  = sel ? B_H  : A_H;
        k  = sel ? 1 : 0;
        d  = 1 + s + st + h;
        address    = addr;
        writedata  = wdata;
        chip_val   = chip;
        read       = !is_w || both;
        write      = is_w || both;
        chipselect = 1'b1;
        req_now    = 1'b1;
        for (int p = 0; p < pre; p++) begin
            @(negedge clk);
            checkOutput("recover_cs_n", {31'd0, obs_cs_n}, 1);
            checkOutput("recover_busy", {31'd0, obs_busy}, 1);
            checkOutput("recover_wait", {31'd0, obs_wait}, 1);
            @(posedge clk); #1;
        end
        for (int c = 0; c <= d; c++) begin
            @(negedge clk);
            cs_on     = (c >= 1) && (c <= s + st + h);
            strobe_on = (c >= s + 1) && (c <= s + st);
            exp_rd    = (!is_w && c > s + st) ? chip : m_rd[k];
            checkOutput($sformatf("cs_n c%0d", c), {31'd0, obs_cs_n}, {31'd0, !cs_on});
            checkOutput($sformatf("rd_n c%0d", c), {31'd0, obs_rd_n}, {31'd0, !(strobe_on && !is_w)});
            checkOutput($sformatf("wr_n c%0d", c), {31'd0, obs_wr_n}, {31'd0, !(strobe_on && is_w)});
            checkOutput($sformatf("oe c%0d", c), {31'd0, obs_oe}, {31'd0, cs_on && is_w});
            checkOutput($sformatf("busy c%0d", c), {31'd0, obs_busy}, {31'd0, c >= 1});
            checkOutput($sformatf("wait c%0d", c), {31'd0, obs_wait}, {31'd0, req_now && (c != d)});
            checkOutput($sformatf("readdata c%0d", c), {16'd0, obs_readdata}, {16'd0, exp_rd});
            checkOutput($sformatf("otg_addr c%0d", c), {30'd0, obs_addr}, {30'd0, (c >= 1) ? addr : m_addr[k]});
            checkOutput($sformatf("data_out c%0d", c), {16'd0, obs_data_out}, {16'd0, (c >= 1) ? wdata : m_dout[k]});
            @(posedge clk); #1;
            if (c == 0) begin
                address   = 2'($urandom);
                writedata = 16'($urandom);
            end
            if (c + 1 == drop_at) begin
                chipselect = 1'b0;
                req_now    = 1'b0;
            end
        end
        m_addr[k] = addr;
        m_dout[k] = wdata;
        if (!is_w) m_rd[k] = chip;
    endtask

    // Master releases the bus; the DUT finishes recovery and returns to IDLE.
    task automatic finishIdle();
        int r;
        r = sel ? B_R : A_R;
        chipselect = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        req_now    = 1'b0;
        for (int p = 0; p < r; p++) begin
            @(negedge clk);
            checkOutput("idle_recover_busy", {31'd0, obs_busy}, 1);
            checkOutput("idle_recover_wait", {31'd0, obs_wait}, 0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        checkOutput("back_to_idle_busy", {31'd0, obs_busy}, 0);
        checkOutput("back_to_idle_cs_n", {31'd0, obs_cs_n}, 1);
        @(posedge clk); #1;
    endtask

    task automatic randomRun(input int n);
        int pre;
        int drop;
        bit keep;
        pre = 0;
        for (int t = 0; t < n; t++) begin
            drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : -1;
            applyStimulus(1'($urandom_range(0, 1)), 1'b0, 2'($urandom), 16'($urandom),
                          16'($urandom), pre, drop);
            keep = (drop < 0) && ($urandom_range(0, 1) == 1) && (t != n - 1);
            if (keep) begin
                pre = sel ? B_R : A_R;
            end else begin
                finishIdle();
                pre = 0;
            end
        end
    endtask

    initial begin
        reset = 1'b1; sel = 1'b0; address = '0; chipselect = 1'b0; read = 1'b0;
        write = 1'b0; writedata = '0; chip_val = '0; req_now = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_rd[k] = '0; m_dout[k] = '0; m_addr[k] = '0;
        end

        // Reset state on both instances.
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            sel = 1'(k);
            #1;
            checkOutput("reset_cs_n", {31'd0, obs_cs_n}, 1);
            checkOutput("reset_rd_n", {31'd0, obs_rd_n}, 1);
            checkOutput("reset_wr_n", {31'd0, obs_wr_n}, 1);
            checkOutput("reset_oe", {31'd0, obs_oe}, 0);
            checkOutput("reset_busy", {31'd0, obs_busy}, 0);
            checkOutput("reset_readdata", {16'd0, obs_readdata}, 0);
            checkOutput("reset_addr", {30'd0, obs_addr}, 0);
            checkOutput("reset_data_out", {16'd0, obs_data_out}, 0);
        end
        sel = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        $display("[TB] single write and single read, default timing");
        applyStimulus(1'b1, 1'b0, 2'd2, 16'h1234, 16'h0000, 0, -1);
        finishIdle();
        applyStimulus(1'b0, 1'b0, 2'd0, 16'h7777, 16'hBEEF, 0, -1);
        finishIdle();

        $display("[TB] back-to-back write then read, req held");
        applyStimulus(1'b1, 1'b0, 2'd1, 16'hCAFE, 16'h0000, 0, -1);
        applyStimulus(1'b0, 1'b0, 2'd0, 16'h0101, 16'h1357, A_R, -1);
        finishIdle();
        checkOutput("b2b_spacing_default", 32'(fall_last - fall_prev), 32'(2 + A_S + A_ST + A_H + A_R));

        $display("[TB] random accesses, default timing");
        randomRun(10);

        $display("[TB] idle request rules");
        chipselect = 1'b0; read = 1'b1; write = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("nocs_cs_n", {31'd0, obs_cs_n}, 1);
            checkOutput("nocs_wait", {31'd0, obs_wait}, 0);
            checkOutput("nocs_busy", {31'd0, obs_busy}, 0);
            @(posedge clk); #1;
        end
        applyStimulus(1'b0, 1'b1, 2'd3, 16'h4242, 16'hA5C3, 0, -1);
        finishIdle();

        $display("[TB] fastest timing instance");
        sel = 1'b1;
        @(posedge clk); #1;
        applyStimulus(1'b1, 1'b0, 2'd3, 16'h0F0F, 16'h0000, 0, -1);
        applyStimulus(1'b0, 1'b0, 2'd1, 16'hF0F0, 16'h2468, B_R, -1);
        finishIdle();
        checkOutput("b2b_spacing_fast", 32'(fall_last - fall_prev), 32'(2 + B_S + B_ST + B_H + B_R));
        randomRun(6);
        sel = 1'b0;
        @(posedge clk); #1;

        $display("[TB] reset during write strobe");
        address = 2'd2; writedata = 16'h3C3C; read = 1'b0; write = 1'b1;
        chipselect = 1'b1; req_now = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("pre_reset_wr_n", {31'd0, obs_wr_n}, 0);
        #2;
        reset = 1'b1;
        chipselect = 1'b0; write = 1'b0; req_now = 1'b0;
        #1;
        checkOutput("async_reset_wr_n", {31'd0, obs_wr_n}, 1);
        checkOutput("async_reset_cs_n", {31'd0, obs_cs_n}, 1);
        checkOutput("async_reset_oe", {31'd0, obs_oe}, 0);
        for (int k = 0; k < 2; k++) begin
            m_rd[k] = '0; m_dout[k] = '0; m_addr[k] = '0;
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_busy", {31'd0, obs_busy}, 0);
        checkOutput("post_reset_readdata", {16'd0, obs_readdata}, {16'd0, m_rd[0]});
        checkOutput("post_reset_addr", {30'd0, obs_addr}, {30'd0, m_addr[0]});
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b0, 2'd0, 16'h1111, 16'h9ABC, 0, -1);
        finishIdle();

        $display("[TB] %0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
